// File: rtl/pet2001_ram_arb.sv
// PET 2001 main RAM port arbiter: CPU owns every ce_1m slot, buffered loader writes fill idle clks.
// Optional PET_LDR_HALT_EN: registered cpu_rdy backpressure with hysteresis on FIFO fill level.
module pet2001_ram_arb #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAM_AW     = 14
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              ce_1m_i,
  input  logic [15:0]       cpu_addr_i,
  input  logic [7:0]        cpu_din_i,
  input  logic              cpu_we_i,
  output logic              cpu_rdy_o,
  input  logic              ld_wr_i,
  input  logic [15:0]       ld_addr_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_full_o,
  output logic              ld_idle_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [7:0]        ram_din_o,
  output logic              ram_we_o,
  output logic              ram_owner_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = RAM_AW + 8;

  typedef enum logic [1:0] {StIdle, StLwr, StGap} state_e;

  state_e          state_q, state_d;
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            fifo_full, fifo_empty, in_window, push, drop, pop;
  logic [EntW-1:0] head;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_window  = (ld_addr_i[15:RAM_AW] == '0);
  // Full check uses the registered count, so a same-cycle pop never rescues a push.
  assign push       = ld_wr_i && in_window && !fifo_full;
  assign drop       = ld_wr_i && !push;
  assign pop        = (state_q == StLwr) && !ce_1m_i;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty && !ce_1m_i) state_d = StLwr;
      StLwr:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {ld_addr_i[RAM_AW-1:0], ld_data_i};
  end

  // A CPU slot always overrides a pending loader write; the entry stays at the head for retry.
  always_comb begin
    ram_addr_o  = cpu_addr_i[RAM_AW-1:0];
    ram_din_o   = cpu_din_i;
    ram_we_o    = cpu_we_i && (cpu_addr_i[15:RAM_AW] == '0);
    ram_owner_o = 1'b0;
    if (pop) begin
      ram_addr_o  = head[EntW-1:8];
      ram_din_o   = head[7:0];
      ram_we_o    = 1'b1;
      ram_owner_o = 1'b1;
    end
  end

  assign ld_full_o  = fifo_full;
  assign ld_idle_o  = fifo_empty && (state_q != StLwr);
  assign drop_cnt_o = drop_cnt_q;

`ifdef PET_LDR_HALT_EN
  logic cpu_rdy_q, cpu_rdy_d;

  always_comb begin
    cpu_rdy_d = cpu_rdy_q;
    if (count_d >= CntW'(FIFO_DEPTH - 1)) cpu_rdy_d = 1'b0;
    else if (count_d <= CntW'(1))         cpu_rdy_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cpu_rdy_q <= 1'b1;
    else           cpu_rdy_q <= cpu_rdy_d;
  end

  assign cpu_rdy_o = cpu_rdy_q;
`else
  assign cpu_rdy_o = 1'b1;
`endif

endmodule

// File: doc/pet2001_ram_arb.md
Name: pet2001_ram_arb

Overview:
- Arbitrates the single port of the 16K main RAM between the CPU and a memory loader (ioctl/PRG injector).
- The CPU owns every ce_1m slot. Loader writes are buffered in a small FIFO and retired in free clk cycles between CPU slots.
- Sits between the CPU address/data bus, the loader and the main RAM instance inside the PET hardware top.

Parameters:
FIFO_DEPTH, 4, loader write FIFO entries; power of 2, min 2
RAM_AW, 14, RAM address width; main RAM window is 0x0000-0x3FFF

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active low
ce_1m  in  1  CPU slot strobe; high for one clk per CPU cycle
cpu_addr  in  16  CPU address
cpu_din  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_rdy  out  1  CPU ready (see Optional Feature)
ld_wr  in  1  loader write strobe, one clk per byte
ld_addr  in  16  loader byte address
ld_data  in  8  loader byte data
ld_full  out  1  FIFO holds FIFO_DEPTH entries
ld_idle  out  1  FIFO empty and no loader write on RAM port
ram_addr  out  RAM_AW  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_owner  out  1  0 = CPU drives RAM port, 1 = loader
drop_cnt  out  8  loader bytes discarded, saturating

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values: FIFO empty, state IDLE, drop_cnt=0, ld_full=0, ld_idle=1, ram_owner=0, ram_we=0 unless CPU write (see mux).
- Push rule: ld_wr=1 with ld_addr[15:14]==0 and FIFO not full pushes {ld_addr[13:0], ld_data}.
- Drop rule: ld_wr=1 with ld_addr outside 0x0000-0x3FFF, or FIFO full, discards the byte and increments drop_cnt (saturates at 255).
- Push when full is dropped even if a pop occurs the same cycle.
- Push and pop in the same cycle with FIFO not full: count unchanged.
- RAM port mux is combinational:
  - When ce_1m=1, or state is not LWR: ram_addr=cpu_addr[13:0], ram_din=cpu_din, ram_we=cpu_we && cpu_addr[15:14]==0, ram_owner=0.
  - When state=LWR and ce_1m=0: ram_addr/ram_din=FIFO head, ram_we=1, ram_owner=1.
- State machine (registered):
  - IDLE -> LWR when FIFO non-empty and ce_1m=0.
  - LWR (one clk):
    - If ce_1m=0: write executes, head popped, -> GAP.
    - If ce_1m=1: CPU wins, no pop, loader write suppressed, -> GAP; the entry is retried.
  - GAP (one clk recovery, CPU may use the port) -> IDLE.
- Latency: ld_wr in cycle N with no contention gives a RAM write in cycle N+2. Minimum spacing of loader writes is 3 clk.
- FIFO ordering is strictly preserved; retried entries are never reordered.
- ld_full and ld_idle are combinational from count and state.
- Reset asserted mid-operation: immediate clear; pending FIFO entries are lost; no partial RAM write after reset_n deasserts.
- Reads are unaffected. RAM read data returns on the CPU address whenever ram_owner=0.

Optional Feature:
- Macro: PET_LDR_HALT_EN.
- Defined:
  - cpu_rdy goes low (registered, one clk after the condition) while FIFO count >= FIFO_DEPTH-1.
  - cpu_rdy stays low until count <= 1, with hysteresis.
  - While cpu_rdy=0, ce_1m slots with cpu_we=0 still pass through the mux.
  - Reset value of cpu_rdy is 1.
- Not defined: cpu_rdy tied to 1; FIFO overflow is handled only by dropping bytes.

Test Plan:
1. Reset, ce_1m=0, ld_wr at 0x0400/0xA9 in cycle N -> ram_we=1, ram_owner=1, ram_addr=0x0400, ram_din=0xA9 in cycle N+2; ld_idle=1 in N+3.
2. Push 0x0010/0x11, force ce_1m=1 exactly in the LWR cycle with cpu_addr=0x0200, cpu_we=1, cpu_din=0x22 -> that cycle has ram_addr=0x0200, ram_din=0x22, ram_owner=0; loader write 0x0010/0x11 lands 3 clk later; FIFO count is unchanged until then.
3. Hold ce_1m=1 continuously, issue 5 ld_wr -> ld_full=1 after the 4th, 5th dropped, drop_cnt=1; release ce_1m -> 4 writes in push order, 3 clk apart.
4. ld_wr at 0x8000/0x41 -> no ram_we with owner=1, drop_cnt increments, ld_idle stays 1.
5. Assert reset_n=0 with 3 entries queued and state=LWR -> ram_owner=0, ld_idle=1, drop_cnt=0 asynchronously; no loader write after release.
6. With PET_LDR_HALT_EN, hold ce_1m=1 and push 3 entries (DEPTH=4) -> cpu_rdy=0 one clk after the 3rd push; release and drain -> cpu_rdy=1 once count<=1.
